ins_prefetch: RTL and testbench

Instruction prefetch stage that sits directly upstream of the single-cycle CPU core. It replaces the core's direct combinational instruction-memory read. It issues in-order word fetches to a latency-variable instruction memory port, buffers returned words with their PCs in a small FIFO, and presents them to the core with a valid/ready handshake. A redirect input, driven by the core's branch/jump logic, flushes the buffer and discards in-flight responses.

---
 rtl/prefetch_pkg.sv | 11 +
 rtl/ins_fifo.sv | 53 +++++
 rtl/ins_prefetch.sv | 90 +++++++++
 tb/tb_ins_prefetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared defaults and the buffered entry layout for the instruction prefetch stage.
package prefetch_pkg;
    localparam int DEFAULT_DEPTH  = 4;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int PC_STEP        = 4;

    typedef struct packed {
        logic [31:0]               instr;
        logic [DEFAULT_ADDR_W-1:0] pc;
    } fifo_entry_t;
endpackage

// File: rtl/ins_fifo.sv
// Small synchronous FIFO with flush; head data is forced to zero while empty.
module ins_fifo
    import prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = $bits(fifo_entry_t)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetch: in-order word fetches, buffered with their PCs, flushed on redirect.
module ins_prefetch
    import prefetch_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PCinit,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] PC_MASK = ~ADDR_W'(PC_STEP-1);

    logic [ADDR_W-1:0]    fpc;
    logic [ADDR_W-1:0]    rpc;
    logic [CW-1:0]        count;
    logic [CW-1:0]        outs;
    logic [CW-1:0]        disc;
    logic [CW:0]          inflight;
    logic                 grant;
    logic                 rsp;
    logic                 drop;
    logic                 push;
    logic                 pop;
    logic [ADDR_W+31:0]   head;

    // buffered plus outstanding words never exceed the FIFO capacity
    assign inflight = {1'b0, count} + {1'b0, outs};
    assign mem_req  = reset && !redirect && (inflight < (CW+1)'(DEPTH));
    assign mem_addr = fpc;

    assign grant = mem_req && mem_gnt;
    assign rsp   = mem_rvalid && (outs != '0);
    assign drop  = rsp && (redirect || (disc != '0));
    assign push  = rsp && !drop;
    assign pop   = ins_valid && ins_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc  <= PCinit & PC_MASK;
            rpc  <= PCinit & PC_MASK;
            outs <= '0;
            disc <= '0;
        end else begin
            if (grant && !rsp)      outs <= outs + CW'(1);
            else if (rsp && !grant) outs <= outs - CW'(1);

            if (redirect) begin
                fpc  <= redirect_pc & PC_MASK;
                rpc  <= redirect_pc & PC_MASK;
                disc <= rsp ? (outs - CW'(1)) : outs;
            end else begin
                if (grant) fpc <= fpc + STEP;
                if (push)  rpc <= rpc + STEP;
                if (rsp && (disc != '0)) disc <= disc - CW'(1);
            end
        end
    end

    ins_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + 32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem_rdata, rpc}),
        .rdata (head),
        .valid (ins_valid),
        .count (count)
    );

    assign instruction = head[ADDR_W+31:ADDR_W];
    assign ins_pc      = head[ADDR_W-1:0];
endmodule

// File: tb/tb_ins_prefetch.sv
// Bench for ins_prefetch: latency-configurable memory model plus an expected-instruction scoreboard.
module tb_ins_prefetch;
    logic        clk;
    logic        reset;
    logic [31:0] PCinit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] instruction;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    ins_prefetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .PCinit      (PCinit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .instruction (instruction),
        .ins_pc      (ins_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;

    req_t        mq[$];
    exp_t        sb[$];
    logic [31:0] pc_log[$];
    logic [31:0] exp_fpc;
    logic [31:0] dx;
    logic [31:0] redir_pc;
    logic        gnt_en, rdy, redir;
    logic        saw_pop, saw_rv;
    int          k, cyc, grants, pops, first_valid;
    int          ntests, nfail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
        if (pc_log.size() > idx) chk(tag, {32'h0, pc_log[idx]}, {32'h0, exp});
        else chk(tag, 64'hFFFF_FFFF_FFFF_FFFF, {32'h0, exp});
    endtask

    // one clock cycle: drive inputs, sample at negedge, update models, advance
    task automatic tick();
        exp_t e;
        mem_gnt     = gnt_en;
        ins_ready   = rdy;
        redirect    = redir;
        redirect_pc = redir_pc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mq[0].addr ^ dx;
            void'(mq.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        @(negedge clk);
        saw_rv  = mem_rvalid;
        saw_pop = ins_valid && ins_ready;
        if (ins_valid && first_valid < 0) first_valid = cyc;
        if (redirect) chk("req_in_redirect", {63'h0, mem_req}, 64'h0);
        if (ins_valid && ins_ready) begin
            pops++;
            pc_log.push_back(ins_pc);
            if (sb.size() == 0) begin
                chk("unexpected_pop", {32'h0, ins_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("ins_pc", {32'h0, ins_pc}, {32'h0, e.pc});
                chk("instruction", {32'h0, instruction}, {32'h0, e.ins});
            end
        end
        if (redirect) begin
            sb.delete();
            exp_fpc = redirect_pc & ~32'h3;
        end
        if (mem_req && mem_gnt) begin
            chk("mem_addr", {32'h0, mem_addr}, {32'h0, exp_fpc});
            mq.push_back('{mem_addr, cyc + k});
            sb.push_back('{exp_fpc, exp_fpc ^ dx});
            exp_fpc = exp_fpc + 32'd4;
            grants++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [31:0] pcinit);
        reset      = 1'b0;
        PCinit     = pcinit;
        redir      = 1'b0;
        redirect   = 1'b0;
        mem_rvalid = 1'b0;
        mq.delete();
        sb.delete();
        exp_fpc = pcinit & ~32'h3;
        @(posedge clk);
        #1;
        chk("rst_ins_valid", {63'h0, ins_valid}, 64'h0);
        chk("rst_instruction", {32'h0, instruction}, 64'h0);
        chk("rst_ins_pc", {32'h0, ins_pc}, 64'h0);
        chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0; grants = 0; pops = 0; first_valid = -1;
        pc_log.delete();
    endtask

    initial begin
        ntests = 0; nfail = 0;
        reset = 1'b0; PCinit = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        ins_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt_en = 1'b1; rdy = 1'b1; redir = 1'b0; redir_pc = '0; dx = '0; k = 1;

        // streaming, single-cycle memory, data equals address
        do_reset(32'h0000_0040);
        repeat (12) tick();
        chk("first_valid_cycle", 64'(first_valid), 64'd2);
        chk_log("first_pc", 0, 32'h40);
        chk("throughput", 64'(pops), 64'd10);

        // core stalled: fill to capacity, then release one slot
        rdy = 1'b0;
        do_reset(32'h0000_0040);
        repeat (8) tick();
        chk("stall_grants", 64'(grants), 64'd4);
        chk("stall_mem_req", {63'h0, mem_req}, 64'h0);
        chk("stall_valid", {63'h0, ins_valid}, 64'h1);
        chk("stall_head_pc", {32'h0, ins_pc}, 64'h40);
        chk("stall_count", 64'(u_dut.count), 64'd4);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        tick();
        chk("refill_grants", 64'(grants), 64'd5);
        repeat (3) tick();
        chk("refill_stop", 64'(grants), 64'd5);
        rdy = 1'b1;
        repeat (10) tick();

        // long latency, redirect with three fetches in flight
        dx = 32'hDEAD_0000; k = 3;
        do_reset(32'h0000_0200);
        repeat (3) tick();
        redir = 1'b1; redir_pc = 32'h0000_0102;
        tick();
        redir = 1'b0;
        chk("redir_rv_seen", {63'h0, saw_rv}, 64'h1);
        chk("redir_empty", {63'h0, ins_valid}, 64'h0);
        chk("redir_disc", 64'(u_dut.disc), 64'd2);
        pc_log.delete();
        repeat (15) tick();
        chk_log("redir_first_pc", 0, 32'h100);
        chk("redir_disc_done", 64'(u_dut.disc), 64'd0);

        // redirect coinciding with a pop and a response
        dx = 32'h1234_0000; k = 2;
        do_reset(32'h0000_1000);
        repeat (8) tick();
        redir = 1'b1; redir_pc = 32'h0000_2001;
        tick();
        redir = 1'b0;
        chk("coinc_pop", {63'h0, saw_pop}, 64'h1);
        chk("coinc_rv", {63'h0, saw_rv}, 64'h1);
        chk("coinc_disc", 64'(u_dut.disc), 64'd1);
        chk("coinc_empty", {63'h0, ins_valid}, 64'h0);
        pc_log.delete();
        repeat (12) tick();
        chk_log("coinc_first_pc", 0, 32'h2000);
        chk_log("coinc_second_pc", 1, 32'h2004);

        // address wrap-around
        dx = 32'h0; k = 1;
        do_reset(32'hFFFF_FFF8);
        repeat (8) tick();
        chk_log("wrap_pc0", 0, 32'hFFFF_FFF8);
        chk_log("wrap_pc1", 1, 32'hFFFF_FFFC);
        chk_log("wrap_pc2", 2, 32'h0000_0000);

        // asynchronous reset with the FIFO full
        rdy = 1'b0;
        do_reset(32'h0000_0040);
        repeat (8) tick();
        chk("pre_areset_valid", {63'h0, ins_valid}, 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid", {63'h0, ins_valid}, 64'h0);
        chk("areset_mem_req", {63'h0, mem_req}, 64'h0);
        rdy = 1'b1;
        do_reset(32'h0000_0080);
        repeat (8) tick();
        chk_log("restart_pc", 0, 32'h80);
        chk_log("restart_pc1", 1, 32'h84);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
